// File: rtl/booth_mult_ctrl_pkg.sv
// Shared types for the radix-2 Booth multiplier controller: FSM states,
// recode operations and the bit-pair recode helper.
package booth_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXAM  = 3'd2,
        S_ADD   = 3'd3,
        S_SUB   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } booth_state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    // {current bit, previous bit}: 10 starts a run of ones, 01 ends one.
    function automatic booth_op_t booth_recode(input logic m0, input logic m_prev);
        booth_op_t op;
        case ({m0, m_prev})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Handshake and datapath strobe bundle between the Booth controller (slave)
// and the issuing logic plus datapath (master).
interface booth_mult_ctrl_if;
    logic start;
    logic abort;
    logic m0;
    logic Load_words;
    logic Shift;
    logic Add;
    logic Sub;
    logic Ready;
    logic busy;
    logic done;

    modport master (
        output start, abort, m0,
        input  Load_words, Shift, Add, Sub, Ready, busy, done
    );

    modport slave (
        input  start, abort, m0,
        output Load_words, Shift, Add, Sub, Ready, busy, done
    );
endinterface

// File: rtl/Mdatapath_booth.sv
// Radix-2 Booth datapath: sign-extended multiplicand shifts left, multiplier
// shifts right, product accumulates +/- multiplicand under controller strobes.
module Mdatapath_booth #(
    parameter int L_word = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [L_word-1:0]     word1,
    input  logic [L_word-1:0]     word2,
    input  logic                  Load_words,
    input  logic                  Shift,
    input  logic                  Add,
    input  logic                  Sub,
    output logic                  m0,
    output logic [2*L_word-1:0]   product
);
    logic [2*L_word-1:0] mcand_q;
    logic [L_word-1:0]   mplier_q;
    logic [2*L_word-1:0] product_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else if (Load_words) begin
            mcand_q   <= {{L_word{word1[L_word-1]}}, word1};
            mplier_q  <= word2;
            product_q <= '0;
        end else if (Shift) begin
            mcand_q   <= mcand_q << 1;
            mplier_q  <= mplier_q >> 1;
        end else if (Add) begin
            product_q <= product_q + mcand_q;
        end else if (Sub) begin
            product_q <= product_q - mcand_q;
        end
    end

    assign m0      = mplier_q[0];
    assign product = product_q;
endmodule

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiplier control FSM with bit counter and Moore strobes.
// Optional BOOTH_CTRL_PERF_EN adds last_cycles/last_ops statistics outputs.
module booth_mult_ctrl
    import booth_pkg::*;
#(
    parameter int L_word = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_mult_ctrl_if.slave    bus
`ifdef BOOTH_CTRL_PERF_EN
    ,
    output logic [$clog2(3*L_word+3)-1:0] last_cycles,
    output logic [$clog2(L_word+1)-1:0]   last_ops
`endif
);
    localparam int CW = $clog2(L_word) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(L_word - 1);

    booth_state_t    state_q, state_d;
    logic            m_prev_q, m_prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_s, shift_s, add_s, sub_s, ready_s, done_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            m_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_prev_q <= m_prev_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_prev_d = m_prev_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;
        shift_s  = 1'b0;
        add_s    = 1'b0;
        sub_s    = 1'b0;
        ready_s  = 1'b0;
        done_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_s = 1'b1;
                if (bus.start && !bus.abort) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_s   = 1'b1;
                m_prev_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_EXAM;
            end
            S_EXAM: begin
                case (booth_recode(bus.m0, m_prev_q))
                    OP_SUB:  state_d = S_SUB;
                    OP_ADD:  state_d = S_ADD;
                    default: state_d = S_SHIFT;
                endcase
            end
            S_ADD: begin
                add_s   = 1'b1;
                state_d = S_SHIFT;
            end
            S_SUB: begin
                sub_s   = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shift_s  = 1'b1;
                m_prev_d = bus.m0;
                cnt_d    = cnt_q + CW'(1);
                state_d  = (cnt_q == CNT_LAST) ? S_DONE : S_EXAM;
            end
            S_DONE: begin
                done_s  = 1'b1;
                ready_s = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // abort overrides every transition except from idle
        if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    assign bus.Load_words = load_s;
    assign bus.Shift      = shift_s;
    assign bus.Add        = add_s;
    assign bus.Sub        = sub_s;
    assign bus.Ready      = ready_s;
    assign bus.busy       = ~ready_s;
    assign bus.done       = done_s;

`ifdef BOOTH_CTRL_PERF_EN
    localparam int PCW = $clog2(3*L_word+3);
    localparam int POW = $clog2(L_word+1);

    logic [PCW-1:0] run_cyc_q, last_cycles_q;
    logic [POW-1:0] ops_q, last_ops_q;

    // run_cyc_q holds the 1-based index of the current cycle since S_LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cyc_q     <= '0;
            ops_q         <= '0;
            last_cycles_q <= '0;
            last_ops_q    <= '0;
        end else begin
            if (state_q == S_IDLE) run_cyc_q <= PCW'(1);
            else                   run_cyc_q <= run_cyc_q + PCW'(1);
            if (state_q == S_LOAD)                          ops_q <= '0;
            else if (state_q == S_ADD || state_q == S_SUB) ops_q <= ops_q + POW'(1);
            if (state_q == S_SHIFT && state_d == S_DONE) begin
                last_cycles_q <= run_cyc_q + PCW'(1);
                last_ops_q    <= ops_q;
            end
        end
    end

    assign last_cycles = last_cycles_q;
    assign last_ops    = last_ops_q;
`endif
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench: Booth controller driving the Booth datapath.
module tb_booth_mult_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] word1, word2;
    logic [7:0] product;
`ifdef BOOTH_CTRL_PERF_EN
    logic [3:0] last_cycles;
    logic [2:0] last_ops;
`endif

    booth_mult_ctrl_if bif();

    Mdatapath_booth #(.L_word(4)) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .word1      (word1),
        .word2      (word2),
        .Load_words (bif.Load_words),
        .Shift      (bif.Shift),
        .Add        (bif.Add),
        .Sub        (bif.Sub),
        .m0         (bif.m0),
        .product    (product)
    );

    booth_mult_ctrl #(.L_word(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
`ifdef BOOTH_CTRL_PERF_EN
        ,
        .last_cycles (last_cycles),
        .last_ops    (last_ops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  w1;
        logic [3:0]  w2;
        logic [7:0]  prod;
        int unsigned cyc;
        int unsigned ops;
    } vec_t;

    typedef struct {
        logic [7:0]  prod;
        int unsigned cyc;
        int unsigned ops;
    } exp_t;

    vec_t        tbl [7];
    exp_t        sb [$];
    int unsigned trace_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          excl_bad = 0;
    int unsigned p_cyc = 0;
    int unsigned p_ops = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned strobe_code();
        if (bif.Load_words) return 1;
        if (bif.Shift)      return 2;
        if (bif.Add)        return 3;
        if (bif.Sub)        return 4;
        if (bif.done)       return 5;
        return 0;
    endfunction

    always @(negedge clk)
        if (rst_n && ($countones({bif.Load_words, bif.Shift, bif.Add, bif.Sub}) > 1))
            excl_bad++;

    task automatic run_op(input vec_t v, input string tag);
        exp_t        e;
        int unsigned k;
        int unsigned nops;
        bit          seen;
        @(negedge clk);
        word1 = v.w1;
        word2 = v.w2;
        bif.start = 1'b1;
        e.prod = v.prod;
        e.cyc  = v.cyc;
        e.ops  = v.ops;
        sb.push_back(e);
        trace_q.delete();
        @(negedge clk);
        bif.start = 1'b0;
        k = 1;
        nops = 0;
        seen = 1'b0;
        while (k <= 40) begin
            trace_q.push_back(strobe_code());
            if (bif.Add || bif.Sub) nops++;
            if (bif.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s_done_seen", tag), seen, 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_cycles", tag), k, e.cyc);
            chk($sformatf("%s_product", tag), product, e.prod);
            chk($sformatf("%s_ops", tag), nops, e.ops);
            chk($sformatf("%s_ready", tag), bif.Ready, 1);
            chk($sformatf("%s_busy", tag), bif.busy, 0);
`ifdef BOOTH_CTRL_PERF_EN
            chk($sformatf("%s_last_cycles", tag), last_cycles, e.cyc);
            chk($sformatf("%s_last_ops", tag), last_ops, e.ops);
`endif
            p_cyc = e.cyc;
            p_ops = e.ops;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_tr [12];
        int unsigned dcnt;
        int unsigned d1, d2;
        int unsigned w;
        bit          seen;
        exp_t        e;

        tbl[0] = '{w1: 4'd5,   w2: 4'b0011, prod: 8'd15,  cyc: 12, ops: 2};
        tbl[1] = '{w1: 4'b1101, w2: 4'b1010, prod: 8'd18,  cyc: 13, ops: 3};
        tbl[2] = '{w1: 4'd9,   w2: 4'd0,    prod: 8'd0,   cyc: 10, ops: 0};
        tbl[3] = '{w1: 4'd7,   w2: 4'b0101, prod: 8'd35,  cyc: 14, ops: 4};
        tbl[4] = '{w1: 4'h8,   w2: 4'h8,    prod: 8'h40,  cyc: 11, ops: 1};
        tbl[5] = '{w1: 4'h7,   w2: 4'hF,    prod: 8'hF9,  cyc: 11, ops: 1};
        tbl[6] = '{w1: 4'hF,   w2: 4'h7,    prod: 8'hF9,  cyc: 12, ops: 2};
        exp_tr = '{1, 0, 4, 2, 0, 2, 0, 3, 2, 0, 2, 5};

        rst_n = 1'b0;
        bif.start = 1'b0;
        bif.abort = 1'b0;
        word1 = '0;
        word2 = '0;
        #12;
        chk("rst_ready", bif.Ready, 1);
        chk("rst_busy", bif.busy, 0);
        chk("rst_strobes", {bif.Load_words, bif.Shift, bif.Add, bif.Sub, bif.done}, 0);
`ifdef BOOTH_CTRL_PERF_EN
        chk("rst_perf", {last_cycles, last_ops}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                chk("trace_len", trace_q.size(), 12);
                for (int j = 0; j < 12; j++)
                    if (j < trace_q.size())
                        chk($sformatf("trace%0d", j), trace_q[j], exp_tr[j]);
            end
        end

        // start held high: two back-to-back operations, DONE + one IDLE between
        @(negedge clk);
        word1 = 4'd5;
        word2 = 4'b0011;
        bif.start = 1'b1;
        e.prod = 8'd15; e.cyc = 12; e.ops = 2;
        sb.push_back(e);
        sb.push_back(e);
        dcnt = 0; d1 = 0; d2 = 0;
        for (int unsigned k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 13) chk("b2b_idle", {bif.Ready, bif.done, bif.Load_words}, 3'b100);
            if (k == 14) chk("b2b_load", bif.Load_words, 1);
            if (bif.done) begin
                dcnt++;
                if (dcnt == 1) d1 = k;
                if (dcnt == 2) d2 = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("b2b_product%0d", dcnt), product, e.prod);
                end
            end
        end
        bif.start = 1'b0;
        chk("b2b_done_count", dcnt, 2);
        chk("b2b_done1_cycle", d1, 12);
        chk("b2b_done2_cycle", d2, 25);
        repeat (16) @(negedge clk);
        chk("b2b_no_third", bif.Ready, 1);
        p_cyc = 12; p_ops = 2;

        // abort in idle suppresses start
        bif.start = 1'b1;
        bif.abort = 1'b1;
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bif.Load_words || !bif.Ready) dcnt++;
        end
        chk("abort_idle_suppress", dcnt, 0);
        bif.start = 1'b0;
        bif.abort = 1'b0;

        // abort in S_ADD
        @(negedge clk);
        word1 = 4'd5;
        word2 = 4'b0011;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        seen = 1'b0;
        for (w = 0; w < 20 && !seen; w++) begin
            if (bif.Add) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort_add_reached", seen, 1);
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        chk("abort_ready", bif.Ready, 1);
        chk("abort_strobes", {bif.Add, bif.Shift, bif.done, bif.busy}, 0);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bif.done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
`ifdef BOOTH_CTRL_PERF_EN
        chk("abort_perf_cycles", last_cycles, p_cyc);
        chk("abort_perf_ops", last_ops, p_ops);
`endif

        // asynchronous reset during S_SHIFT
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        seen = 1'b0;
        for (w = 0; w < 20 && !seen; w++) begin
            if (bif.Shift) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rstmid_shift_reached", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_ready", bif.Ready, 1);
        chk("rstmid_strobes", {bif.Load_words, bif.Shift, bif.Add, bif.Sub, bif.done, bif.busy}, 0);
`ifdef BOOTH_CTRL_PERF_EN
        chk("rstmid_perf", {last_cycles, last_ops}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op(tbl[3], "recover");

        chk("sb_empty", sb.size(), 0);
        chk("strobe_exclusive", excl_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/booth_mult_ctrl.md
Name: booth_mult_ctrl

Overview:
Control unit for the radix-2 Booth multiplier. Sits directly upstream of the Booth datapath (Mdatapath_booth) and drives its Load_words/Shift/Add/Sub/Ready strobes. It reads the datapath's multiplier LSB (m0) and tracks the previous multiplier bit to recode each bit pair into add, subtract or skip. Exposes a start/busy/done handshake to the issuing logic.

Parameters:
L_word, 4, operand width; must match the datapath's L_word; number of Booth iterations.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only in S_IDLE
abort  input  1  synchronous cancel; returns the FSM to S_IDLE
m0  input  1  datapath multiplier[0]
Load_words  output  1  datapath load strobe
Shift  output  1  datapath shift strobe
Add  output  1  datapath product += multiplicand
Sub  output  1  datapath product -= multiplicand
Ready  output  1  controller idle or finished; datapath product valid
busy  output  1  equals ~Ready
done  output  1  one-cycle pulse; product final

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: state=S_IDLE, m_prev=0, cnt=0. Outputs during reset: Load_words/Shift/Add/Sub/done=0, Ready=1, busy=0.
- Output decode: all strobes are Moore outputs, decoded from the registered state only. At most one of Load_words/Shift/Add/Sub is high in any cycle.
- States and transitions:
  - S_IDLE: Ready=1. If start=1 and abort=0, go to S_LOAD.
  - S_LOAD: Load_words=1. Sets m_prev<=0 and cnt<=0. Go to S_EXAM.
  - S_EXAM: no strobes. Recode {m0,m_prev}:
    - 2'b10 -> S_SUB
    - 2'b01 -> S_ADD
    - 2'b00 or 2'b11 -> S_SHIFT
  - S_ADD: Add=1. Go to S_SHIFT.
  - S_SUB: Sub=1. Go to S_SHIFT.
  - S_SHIFT: Shift=1. Sets m_prev<=m0 (the pre-shift value) and cnt<=cnt+1. If cnt==L_word-1, go to S_DONE; otherwise go to S_EXAM.
  - S_DONE: done=1 and Ready=1 for exactly one cycle. Go to S_IDLE. A start seen in S_DONE is ignored.
- Counter: cnt has width $clog2(L_word)+1. It never wraps within an operation.
- Latency: start is sampled at edge E0; S_LOAD occupies cycle 1.
  - Per bit: 2 cycles (skip) or 3 cycles (add/sub).
  - Total: 2+2*L_word+(number of add/sub ops) cycles, S_LOAD through S_DONE inclusive.
  - Range for L_word=4: minimum 10, maximum 14.
- Final shift: the shift after the last bit is always issued. It is harmless to the product.
- start while busy: ignored. There is no queueing.
- abort:
  - In any state other than S_IDLE: next state is S_IDLE. No done pulse. Product is invalid.
  - In S_IDLE: abort has no effect, and start is suppressed while abort=1.
- rst_n asserted mid-operation: immediate return to S_IDLE with reset values. No done pulse.
- Unreachable state encodings: recover to S_IDLE.

Optional Feature:
- Macro: BOOTH_CTRL_PERF_EN.
- When defined:
  - Adds output last_cycles, width $clog2(3*L_word+3), reset 0. It holds the cycle count from S_LOAD to S_DONE inclusive of the last completed operation and updates when S_DONE is entered.
  - Adds output last_ops, width $clog2(L_word+1), reset 0. It holds the number of Add+Sub strobes issued in that operation.
  - Aborted operations do not update either output.
- When undefined: neither port nor its logic exists. Behaviour is otherwise identical.

Decomposition:
- Package booth_pkg contains:
  - typedef enum logic [2:0] booth_state_t {S_IDLE,S_LOAD,S_EXAM,S_ADD,S_SUB,S_SHIFT,S_DONE}
  - typedef enum logic [1:0] booth_op_t {OP_NONE,OP_ADD,OP_SUB}
  - function booth_recode(m0,m_prev) returning booth_op_t
- No sub-module: the FSM plus counter is a single module.
- The bench instantiates booth_mult_ctrl together with Mdatapath_booth.

Test Plan:
- L_word=4, word1=5, word2=4'b0011, pulse start -> strobe order LOAD,EXAM,SUB,SHIFT,EXAM,SHIFT,EXAM,ADD,SHIFT,EXAM,SHIFT,DONE; done in cycle 12 after start; product=8'd15.
- word1=4'b1101 (-3), word2=4'b1010 (-6) -> 1 Add and 2 Subs; done at cycle 13; product=8'd18.
- word2=0 -> no Add/Sub; done at cycle 10; product=0. word2=4'b0101 with word1=7 -> done at cycle 14 (max); product=8'd35.
- start held high continuously -> back-to-back operations separated by S_DONE and one S_IDLE cycle; start pulses during busy are ignored (exactly one done per accepted start).
- abort asserted in S_ADD -> S_IDLE next cycle, no done, Ready=1. rst_n dropped mid-S_SHIFT -> outputs go to reset values asynchronously, before the next clk edge.
- With BOOTH_CTRL_PERF_EN, after the first test -> last_cycles=12, last_ops=2; an aborted run leaves both unchanged.
